mul_sched: RTL

MUL_SCHED -- requirements
Module: mul_sched

---
 rtl/mul_pkg.sv | 16 +
 rtl/mul_sched_if.sv | 47 ++++
 rtl/mul_core.sv | 78 +++++++
 rtl/mul_sched.sv | 129 ++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types and defaults for the mul_sched multiplier scheduler.
// Holds the FSM state encoding and the stage-counter width.
package mul_pkg;

  localparam int MUL_WIDTH  = 8;
  localparam int MUL_STAGES = 3;
  localparam int CNT_W      = 3;

  typedef enum logic [1:0] {
    IDLE,
    COMPRESS,
    CPA,
    DONE
  } state_t;

endpackage

// File: rtl/mul_sched_if.sv
// Requester/consumer bundle around mul_sched.
// master drives requests and resp_ready; slave is the scheduler side.
interface mul_sched_if
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) ();

  logic             req0_valid;
  logic             req1_valid;
  logic             req0_ready;
  logic             req1_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req0_signed;
  logic             req1_signed;
  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [2*WIDTH-1:0] resp_p;
  logic             busy;

  modport master (
    output req0_valid, req1_valid,
    output req0_a, req0_b,
    output req1_a, req1_b,
    output req0_signed, req1_signed,
    output resp_ready,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_id,
    input  resp_p, busy
  );

  modport slave (
    input  req0_valid, req1_valid,
    input  req0_a, req0_b,
    input  req1_a, req1_b,
    input  req0_signed, req1_signed,
    input  resp_ready,
    output req0_ready, req1_ready,
    output resp_valid, resp_id,
    output resp_p, busy
  );

endinterface

// File: rtl/mul_core.sv
// Multiplier datapath: partial products, carry-save compression
// spread over STAGES cycles, then a registered carry-propagate add.
module mul_core
  import mul_pkg::*;
#(
  parameter int WIDTH  = MUL_WIDTH,
  parameter int STAGES = MUL_STAGES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               sgn,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               stg_en,
  input  logic [CNT_W-1:0]   stg_idx,
  input  logic               cpa_en,
  output logic [2*WIDTH-1:0] p
);

  localparam int PW = 2 * WIDTH;

  logic [PW-1:0] ax;
  logic [PW-1:0] bx;
  logic [PW-1:0] s_q;
  logic [PW-1:0] c_q;
  logic [PW-1:0] s_d;
  logic [PW-1:0] c_d;
  logic [PW-1:0] row;
  logic [PW-1:0] sum;
  logic [PW-1:0] ext_a;
  logic [PW-1:0] ext_b;

  // Extending to 2*WIDTH makes the mod-2^PW product exact for both modes
  assign ext_a = sgn ? {{WIDTH{a[WIDTH-1]}}, a}
                     : {{WIDTH{1'b0}}, a};
  assign ext_b = sgn ? {{WIDTH{b[WIDTH-1]}}, b}
                     : {{WIDTH{1'b0}}, b};

  always_comb begin
    s_d = s_q;
    c_d = c_q;
    row = '0;
    sum = '0;
    for (int i = 0; i < PW; i++) begin
      if (i % STAGES == int'(stg_idx)) begin
        row = bx[i] ? (ax << i) : '0;
        sum = s_d ^ c_d ^ row;
        c_d = ((s_d & c_d) | (s_d & row) | (c_d & row)) << 1;
        s_d = sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ax  <= '0;
      bx  <= '0;
      s_q <= '0;
      c_q <= '0;
      p   <= '0;
    end else begin
      if (load) begin
        ax  <= ext_a;
        bx  <= ext_b;
        s_q <= '0;
        c_q <= '0;
      end else if (stg_en) begin
        s_q <= s_d;
        c_q <= c_d;
      end
      if (cpa_en) begin
        p <= s_q + c_q;
      end
    end
  end

endmodule

// File: rtl/mul_sched.sv
// Two-requester round-robin multiplier scheduler over mul_core.
// Define MUL_SCHED_SIGNED_EN to add per-request two's complement mode.
module mul_sched
  import mul_pkg::*;
#(
  parameter int WIDTH  = MUL_WIDTH,
  parameter int STAGES = MUL_STAGES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  input  logic               req1_valid,
  output logic               req0_ready,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
`ifdef MUL_SCHED_SIGNED_EN
  input  logic               req0_signed,
  input  logic               req1_signed,
`endif
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_id,
  output logic [2*WIDTH-1:0] resp_p,
  output logic               busy
);

  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] cnt;
  logic             ptr;
  logic             accept;
  logic             last_stg;
  logic             stg_en;
  logic             cpa_en;
  logic             sgn_sel;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;

  assign last_stg = (cnt == CNT_W'(STAGES - 1));
  assign accept   = req0_ready | req1_ready;
  assign a_sel    = req1_ready ? req1_a : req0_a;
  assign b_sel    = req1_ready ? req1_b : req0_b;

`ifdef MUL_SCHED_SIGNED_EN
  assign sgn_sel  = req1_ready ? req1_signed : req0_signed;
`else
  assign sgn_sel  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:     if (accept) nxt = COMPRESS;
      COMPRESS: if (last_stg) nxt = CPA;
      CPA:      nxt = DONE;
      DONE:     if (resp_ready) nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  // ptr high means req1 wins a tie; readys are gated by rst_n
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    busy       = 1'b1;
    resp_valid = 1'b0;
    stg_en     = 1'b0;
    cpa_en     = 1'b0;
    unique case (state)
      IDLE: begin
        busy       = 1'b0;
        req0_ready = rst_n & req0_valid
                   & (~req1_valid | ~ptr);
        req1_ready = rst_n & req1_valid
                   & (~req0_valid | ptr);
      end
      COMPRESS: stg_en     = 1'b1;
      CPA:      cpa_en     = 1'b1;
      DONE:     resp_valid = 1'b1;
      default:  busy       = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state == COMPRESS) begin
      cnt <= last_stg ? '0 : cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= 1'b0;
      resp_id <= 1'b0;
    end else if (accept) begin
      ptr     <= req0_ready;
      resp_id <= req1_ready;
    end
  end

  mul_core #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept),
    .sgn     (sgn_sel),
    .a       (a_sel),
    .b       (b_sel),
    .stg_en  (stg_en),
    .stg_idx (cnt),
    .cpa_en  (cpa_en),
    .p       (resp_p)
  );

endmodule
